// File: rtl/latch_write_sequencer_pkg.sv
// Shared definitions for the latch write sequencer.
//   state_t      : sequencer states with fixed 2-bit encodings
//   ERR_CNT_MAX  : saturation value of the mismatch counter
//   cnt_width()  : phase-counter width from the three timing parameters
package latch_write_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // The counter is loaded with (cycles - 1), so it must hold max-1.
  function automatic int cnt_width(input int setup_cyc, input int pulse_cyc,
                                   input int hold_cyc);
    int m;
    m = setup_cyc;
    if (pulse_cyc > m) m = pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/latch_write_sequencer_if.sv
// Bus between a word source / latch bank and the sequencer.
//   in_data/in_valid/in_ready : upstream valid/ready handshake
//   d/c                       : latch data and enable, driven by sequencer
//   q/qbar                    : latch outputs read back
//   busy/done/mismatch/err_cnt: status
// slave  : sequencer side
// master : environment side (source plus latch bank)
interface latch_write_sequencer_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             c;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [7:0]       err_cnt;

  modport slave (
    input  in_data, in_valid, q, qbar,
    output in_ready, d, c, busy, done, mismatch, err_cnt
  );

  modport master (
    output in_data, in_valid, q, qbar,
    input  in_ready, d, c, busy, done, mismatch, err_cnt
  );
endinterface

// File: rtl/latch_write_sequencer_phase_counter.sv
// Loadable down-counter with zero flag, timing every SETUP/PULSE/HOLD phase.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this edge (takes priority over counting)
//   load_val   : remaining cycles minus one
//   zero       : counter has reached zero (last cycle of the phase)
module phase_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (load)    cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/latch_write_sequencer.sv
// Upstream driver for a level-sensitive D latch bank. Accepts a word over
// valid/ready, then drives D with C low for SETUP_CYC cycles, C high for
// PULSE_CYC cycles, C low for HOLD_CYC cycles, and finally compares the
// latch Q/QBAR read-back against D.
//   clk, rst_n : clock, async active-low reset (forces all outputs low)
//   bus        : latch_write_sequencer_if.slave (handshake, latch, status)
module latch_write_sequencer
  import latch_write_sequencer_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  latch_write_sequencer_if.slave   bus
);
  localparam int CNT_W = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  generate
    if (PULSE_CYC < 1 || HOLD_CYC < 1 || SETUP_CYC < 0) begin : g_bad_params
      $error("latch_write_sequencer: PULSE_CYC and HOLD_CYC must be >= 1");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] d_r;
  logic             c_r;
  logic             done_r;
  logic             mismatch_r;
  logic [7:0]       err_r;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             rb_bad;

  phase_counter #(.W(CNT_W)) u_phase_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Counter is reloaded on every state entry with (phase length - 1).
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state)
      IDLE: if (bus.in_valid) begin
        cnt_load = 1'b1;
        cnt_val  = (SETUP_CYC > 0) ? CNT_W'(SETUP_CYC - 1) : CNT_W'(PULSE_CYC - 1);
      end
      SETUP: if (cnt_zero) begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(PULSE_CYC - 1);
      end
      PULSE: if (cnt_zero) begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(HOLD_CYC - 1);
      end
      HOLD: ;
      default: ;
    endcase
  end

  // A healthy latch shows Q equal to D and QBAR as the exact complement.
  assign rb_bad = (bus.q != d_r) || (bus.qbar != ~bus.q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      d_r        <= '0;
      c_r        <= 1'b0;
      done_r     <= 1'b0;
      mismatch_r <= 1'b0;
      err_r      <= '0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: if (bus.in_valid) begin
          d_r        <= bus.in_data;
          mismatch_r <= 1'b0;
          if (SETUP_CYC > 0) begin
            state <= SETUP;
          end else begin
            // No setup window: D and C rise together; D is still held
            // through the whole pulse and hold window.
            state <= PULSE;
            c_r   <= 1'b1;
          end
        end
        SETUP: if (cnt_zero) begin
          state <= PULSE;
          c_r   <= 1'b1;
        end
        PULSE: if (cnt_zero) begin
          state <= HOLD;
          c_r   <= 1'b0;
        end
        HOLD: if (cnt_zero) begin
          state      <= IDLE;
          done_r     <= 1'b1;
          mismatch_r <= rb_bad;
          if (rb_bad && err_r != ERR_CNT_MAX) err_r <= err_r + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is gated by rst_n so every output reads low while in reset.
  assign bus.in_ready = rst_n && (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.d        = d_r;
  assign bus.c        = c_r;
  assign bus.done     = done_r;
  assign bus.mismatch = mismatch_r;
  assign bus.err_cnt  = err_r;
endmodule

// File: tb/tb_latch_write_sequencer.sv
// Directed bench: two sequencers (1-bit defaults, and 4-bit with no setup)
// each driving a behavioural D latch whose Q can be forced stuck.
module tb_latch_write_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  latch_write_sequencer_if #(.WIDTH(1)) if_a ();
  latch_write_sequencer_if #(.WIDTH(4)) if_b ();

  latch_write_sequencer #(.WIDTH(1), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_dut_a (
    .clk (clk), .rst_n (rst_n), .bus (if_a)
  );
  latch_write_sequencer #(.WIDTH(4), .SETUP_CYC(0), .PULSE_CYC(3), .HOLD_CYC(2)) u_dut_b (
    .clk (clk), .rst_n (rst_n), .bus (if_b)
  );

  // Behavioural latches plus a stuck-at override on bank A.
  logic       lat_a = 1'b0;
  logic [3:0] lat_b = 4'h0;
  logic       stuck_en = 1'b0;
  logic       stuck_val = 1'b0;
  always_latch if (if_a.c) lat_a = if_a.d;
  always_latch if (if_b.c) lat_b = if_b.d;
  assign if_a.q    = stuck_en ? stuck_val : lat_a;
  assign if_a.qbar = ~if_a.q;
  assign if_b.q    = lat_b;
  assign if_b.qbar = ~if_b.q;

  // D must never move while C is high.
  int d_moves_under_c = 0;
  always @(if_a.d) if (if_a.c && rst_n) d_moves_under_c++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on bank A: accept edge plus 7 more edges, so on return
  // the sequencer is in its first IDLE cycle with DONE high.
  task automatic write_a(input logic val);
    if_a.in_data  = val;
    if_a.in_valid = 1'b1;
    tick();
    if_a.in_valid = 1'b0;
    repeat (7) tick();
  endtask

  initial begin
    logic [6:0] c_pat;
    logic [4:0] cb_pat;
    int gap;
    bit got;
    int done_seen;

    if_a.in_data = '0; if_a.in_valid = 1'b0;
    if_b.in_data = '0; if_b.in_valid = 1'b0;

    // ---- reset state ----
    #12;
    check("rst_in_ready", 32'(if_a.in_ready), 32'd0);
    check("rst_c", 32'(if_a.c), 32'd0);
    check("rst_d", 32'(if_a.d), 32'd0);
    check("rst_err", 32'(if_a.err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(if_a.in_ready), 32'd1);
    check("post_rst_busy", 32'(if_a.busy), 32'd0);
    check("post_rst_done", 32'(if_a.done), 32'd0);
    check("post_rst_mismatch", 32'(if_a.mismatch), 32'd0);

    // ---- 1: single write of 1, C low 2 / high 3 / low 2 ----
    if_a.in_data = 1'b1; if_a.in_valid = 1'b1;
    tick();
    if_a.in_valid = 1'b0;
    check("t1_busy", 32'(if_a.busy), 32'd1);
    check("t1_in_ready", 32'(if_a.in_ready), 32'd0);
    check("t1_d", 32'(if_a.d), 32'd1);
    c_pat = 7'b0011100; // index 6 = accept edge, down to index 0
    for (int i = 6; i >= 0; i--) begin
      check($sformatf("t1_c_%0d", 6 - i), 32'(if_a.c), 32'(c_pat[i]));
      check($sformatf("t1_done_%0d", 6 - i), 32'(if_a.done), 32'd0);
      tick();
    end
    check("t1_done", 32'(if_a.done), 32'd1);
    check("t1_q", 32'(if_a.q), 32'd1);
    check("t1_mismatch", 32'(if_a.mismatch), 32'd0);
    check("t1_err", 32'(if_a.err_cnt), 32'd0);
    tick();
    check("t1_done_once", 32'(if_a.done), 32'd0);

    // ---- 2: back-to-back with in_valid held ----
    if_a.in_data = 1'b1; if_a.in_valid = 1'b1;
    tick();
    if_a.in_data = 1'b0;
    gap = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (if_a.in_ready) begin
        got = 1;
        check("t2_q_first", 32'(if_a.q), 32'd1);
      end
      tick();
      gap++;
    end
    if_a.in_valid = 1'b0;
    check("t2_gap", 32'(gap), 32'd8);
    repeat (7) tick();
    check("t2_done", 32'(if_a.done), 32'd1);
    check("t2_q_second", 32'(if_a.q), 32'd0);
    check("t2_d_stable_under_c", 32'(d_moves_under_c), 32'd0);

    // ---- 3: stuck-at-0 Q, then a matching write ----
    stuck_en = 1'b1; stuck_val = 1'b0;
    write_a(1'b1);
    check("t3_done", 32'(if_a.done), 32'd1);
    check("t3_mismatch", 32'(if_a.mismatch), 32'd1);
    check("t3_err", 32'(if_a.err_cnt), 32'd1);
    repeat (2) tick();
    check("t3_mismatch_sticky", 32'(if_a.mismatch), 32'd1);
    write_a(1'b0);
    check("t3_mismatch_clear", 32'(if_a.mismatch), 32'd0);
    check("t3_err_hold", 32'(if_a.err_cnt), 32'd1);
    stuck_en = 1'b0;

    // ---- 4: async reset during second PULSE cycle ----
    if_a.in_data = 1'b1; if_a.in_valid = 1'b1;
    tick();
    if_a.in_valid = 1'b0;
    repeat (3) tick();
    check("t4_c_in_pulse", 32'(if_a.c), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_c_async", 32'(if_a.c), 32'd0);
    check("t4_d_async", 32'(if_a.d), 32'd0);
    check("t4_err_async", 32'(if_a.err_cnt), 32'd0);
    #14 rst_n = 1'b1;
    tick();
    check("t4_in_ready", 32'(if_a.in_ready), 32'd1);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (if_a.done) done_seen++;
      tick();
    end
    check("t4_no_done", 32'(done_seen), 32'd0);
    check("t4_err", 32'(if_a.err_cnt), 32'd0);

    // ---- 5: WIDTH=4, no setup window, write 4'hA ----
    if_b.in_data = 4'hA; if_b.in_valid = 1'b1;
    tick();
    if_b.in_valid = 1'b0;
    check("t5_d", 32'(if_b.d), 32'hA);
    cb_pat = 5'b11100;
    for (int i = 4; i >= 0; i--) begin
      check($sformatf("t5_c_%0d", 4 - i), 32'(if_b.c), 32'(cb_pat[i]));
      check($sformatf("t5_done_%0d", 4 - i), 32'(if_b.done), 32'd0);
      tick();
    end
    check("t5_done", 32'(if_b.done), 32'd1);
    check("t5_q", 32'(if_b.q), 32'hA);
    check("t5_mismatch", 32'(if_b.mismatch), 32'd0);

    // ---- 6: saturating error counter ----
    stuck_en = 1'b1; stuck_val = 1'b0;
    for (int i = 0; i < 254; i++) write_a(1'b1);
    check("t6_err_254", 32'(if_a.err_cnt), 32'd254);
    write_a(1'b1);
    check("t6_err_255", 32'(if_a.err_cnt), 32'd255);
    for (int i = 0; i < 5; i++) write_a(1'b1);
    check("t6_err_sat", 32'(if_a.err_cnt), 32'd255);
    check("t6_mismatch", 32'(if_a.mismatch), 32'd1);
    stuck_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
